// File: rtl/rename_map_table_if.sv
// rename_map_table_if
//   Bundles the rename pipeline and free-list handshake signals of the
//   register rename map table. clk and reset stay plain module ports.
//
//   Signals (direction shown from the map table, the slave side):
//     en, rewind, rename           in   : stall enable, recovery, rename request
//     srcA, srcB, dest, destValid  in   : architectural operands of the instruction
//     newPhys                      in   : free physical register offered by the free list
//     takeReq                      out  : combinational take strobe to the free list
//     commit, commitDest,
//     commitPhys                   in   : retiring mapping
//     outValid, outPhysA, outPhysB,
//     outPhysDest, outOldPhys      out  : registered rename results
//
//   Modports: master = pipeline / testbench side, slave = rename_map_table.
interface rename_map_table_if;
  logic       en;
  logic       rewind;
  logic       rename;
  logic [4:0] srcA;
  logic [4:0] srcB;
  logic [4:0] dest;
  logic       destValid;
  logic [5:0] newPhys;
  logic       takeReq;
  logic       commit;
  logic [4:0] commitDest;
  logic [5:0] commitPhys;
  logic       outValid;
  logic [5:0] outPhysA;
  logic [5:0] outPhysB;
  logic [5:0] outPhysDest;
  logic [5:0] outOldPhys;

  modport master (
    output en, rewind, rename, srcA, srcB, dest, destValid, newPhys,
    output commit, commitDest, commitPhys,
    input  takeReq, outValid, outPhysA, outPhysB, outPhysDest, outOldPhys
  );

  modport slave (
    input  en, rewind, rename, srcA, srcB, dest, destValid, newPhys,
    input  commit, commitDest, commitPhys,
    output takeReq, outValid, outPhysA, outPhysB, outPhysDest, outOldPhys
  );
endinterface

// File: rtl/rename_map_table.sv
// rename_map_table
//   Register rename map table with a speculative map (specMap) and a
//   committed map (commMap), 32 architectural x 6-bit physical entries each.
//   A rename reads both sources and the old destination mapping from specMap
//   (read-before-write, so aliased operands all see the pre-update values),
//   writes the new destination mapping on the same edge, and registers the
//   results one cycle later. Commits update commMap; rewind restores specMap
//   from commMap, including a commit on the same edge.
//
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     reset : synchronous active-high reset, overrides everything
//     bus   : rename_map_table_if.slave (see interface header)
//
//   Optional feature:
//     RMT_ZERO_REG_EN - architectural register 0 is hardwired to physical 0:
//                       source reads return 0, dest 0 behaves as destValid=0,
//                       and commits to register 0 are ignored.
//
//   Handshake: takeReq is a pulse-per-cycle consume strobe toward the free
//   list. newPhys is assumed valid whenever takeReq is high (the free list has
//   no ready/empty back-pressure here; upstream must deassert en instead), and
//   the offered register is consumed on the rising edge where takeReq=1.
//   outValid is a single-cycle valid with no ready: downstream must accept it.
module rename_map_table (
  input logic                     clk,
  input logic                     reset,
  rename_map_table_if.slave       bus
);

  logic [5:0] spec_map [32];
  logic [5:0] comm_map [32];

  logic       dest_valid_eff;
  logic       commit_eff;
  logic       accept;
  logic       take;
  logic [5:0] rd_a;
  logic [5:0] rd_b;
  logic [5:0] rd_d;

  logic       out_valid_q;
  logic [5:0] out_phys_a_q;
  logic [5:0] out_phys_b_q;
  logic [5:0] out_phys_dest_q;
  logic [5:0] out_old_phys_q;

`ifdef RMT_ZERO_REG_EN
  assign dest_valid_eff = bus.destValid & (bus.dest != 5'd0);
  assign commit_eff     = bus.commit & (bus.commitDest != 5'd0);
  assign rd_a = (bus.srcA == 5'd0) ? 6'd0 : spec_map[bus.srcA];
  assign rd_b = (bus.srcB == 5'd0) ? 6'd0 : spec_map[bus.srcB];
  assign rd_d = (bus.dest == 5'd0) ? 6'd0 : spec_map[bus.dest];
`else
  assign dest_valid_eff = bus.destValid;
  assign commit_eff     = bus.commit;
  assign rd_a = spec_map[bus.srcA];
  assign rd_b = spec_map[bus.srcB];
  assign rd_d = spec_map[bus.dest];
`endif

  // A rename concurrent with rewind is dropped: it belongs to the squashed path.
  assign accept      = bus.en & bus.rename & ~bus.rewind;
  assign take        = accept & dest_valid_eff;
  assign bus.takeReq = take;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        spec_map[i] <= 6'(i);
        comm_map[i] <= 6'(i);
      end
      out_valid_q     <= 1'b0;
      out_phys_a_q    <= 6'd0;
      out_phys_b_q    <= 6'd0;
      out_phys_dest_q <= 6'd0;
      out_old_phys_q  <= 6'd0;
    end else if (bus.en) begin
      if (commit_eff) begin
        comm_map[bus.commitDest] <= bus.commitPhys;
      end

      if (bus.rewind) begin
        // Forward the same-edge commit so the restored map is up to date.
        for (int i = 0; i < 32; i++) begin
          if (commit_eff && (bus.commitDest == 5'(i))) begin
            spec_map[i] <= bus.commitPhys;
          end else begin
            spec_map[i] <= comm_map[i];
          end
        end
      end else if (take) begin
        spec_map[bus.dest] <= bus.newPhys;
      end

      out_valid_q <= accept;
      if (accept) begin
        out_phys_a_q    <= rd_a;
        out_phys_b_q    <= rd_b;
        out_old_phys_q  <= rd_d;
        out_phys_dest_q <= dest_valid_eff ? bus.newPhys : rd_d;
      end
    end
  end

  assign bus.outValid    = out_valid_q;
  assign bus.outPhysA    = out_phys_a_q;
  assign bus.outPhysB    = out_phys_b_q;
  assign bus.outPhysDest = out_phys_dest_q;
  assign bus.outOldPhys  = out_old_phys_q;

endmodule

// File: tb/tb_rename_map_table.sv
// tb_rename_map_table
//   Directed scenarios followed by randomized traffic, each cycle compared
//   against a behavioural map-table model held in plain integer arrays.
//   Honors RMT_ZERO_REG_EN the same way the design does.
module tb_rename_map_table;

`ifdef RMT_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rename_map_table_if bus ();

  rename_map_table dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [24:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_spec[32];
  int m_comm[32];
  int m_valid, m_a, m_b, m_dest, m_old;

  function automatic int m_read(input int r);
    if (ZERO_REG && r == 0) return 0;
    return m_spec[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_spec[i] = i;
      m_comm[i] = i;
    end
    m_valid = 0; m_a = 0; m_b = 0; m_dest = 0; m_old = 0;
  endtask

  // Applies one rising edge worth of behaviour given the current inputs.
  task automatic model_edge();
    bit dv, cm;
    int sa, sb, d, cd;
    sa = bus.srcA; sb = bus.srcB; d = bus.dest; cd = bus.commitDest;
    dv = bus.destValid && !(ZERO_REG && d == 0);
    cm = bus.commit && !(ZERO_REG && cd == 0);
    if (reset) begin
      model_reset();
    end else if (bus.en) begin
      if (bus.rename && !bus.rewind) begin
        m_valid = 1;
        m_a     = m_read(sa);
        m_b     = m_read(sb);
        m_old   = m_read(d);
        m_dest  = dv ? int'(bus.newPhys) : m_read(d);
      end else begin
        m_valid = 0;
      end
      if (cm) m_comm[cd] = bus.commitPhys;
      if (bus.rewind) begin
        for (int i = 0; i < 32; i++) m_spec[i] = m_comm[i];
      end else if (bus.rename && dv) begin
        m_spec[d] = bus.newPhys;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit en, input bit rw, input bit rn,
                       input int a, input int b, input int d, input bit dv, input int np,
                       input bit c, input int cd, input int cp);
    bus.en         = en;
    bus.rewind     = rw;
    bus.rename     = rn;
    bus.srcA       = 5'(a);
    bus.srcB       = 5'(b);
    bus.dest       = 5'(d);
    bus.destValid  = dv;
    bus.newPhys    = 6'(np);
    bus.commit     = c;
    bus.commitDest = 5'(cd);
    bus.commitPhys = 6'(cp);
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: check takeReq before the edge, model the edge, check outputs after.
  task automatic cycle();
    logic [24:0] e;
    bit exp_take;
    #1;
    exp_take = bus.en && bus.rename && bus.destValid && !bus.rewind &&
               !(ZERO_REG && bus.dest == 5'd0);
    check("takeReq", 32'(bus.takeReq), 32'(exp_take));
    model_edge();
    exp_q.push_back({1'(m_valid), 6'(m_a), 6'(m_b), 6'(m_dest), 6'(m_old)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("outValid",    32'(bus.outValid),    32'(e[24]));
    check("outPhysA",    32'(bus.outPhysA),    32'(e[23:18]));
    check("outPhysB",    32'(bus.outPhysB),    32'(e[17:12]));
    check("outPhysDest", 32'(bus.outPhysDest), 32'(e[11:6]));
    check("outOldPhys",  32'(bus.outOldPhys),  32'(e[5:0]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    check("rst_valid", 32'(bus.outValid), 0);
    check("rst_a",     32'(bus.outPhysA), 0);
    reset = 1'b0;

    // First rename after reset reads identity mappings.
    drive(1, 0, 1, 5, 7, 9, 1, 32, 0, 0, 0);
    cycle();
    check("r030_a",    32'(bus.outPhysA),    5);
    check("r030_b",    32'(bus.outPhysB),    7);
    check("r030_old",  32'(bus.outOldPhys),  9);
    check("r030_dest", 32'(bus.outPhysDest), 32);

    // Back-to-back: second rename sees the first one's mapping.
    drive(1, 0, 1, 9, 1, 9, 1, 33, 0, 0, 0);
    cycle();
    check("r031_a",    32'(bus.outPhysA),    32);
    check("r031_old",  32'(bus.outOldPhys),  32);
    check("r031_dest", 32'(bus.outPhysDest), 33);

    // Aliased operands read the pre-update mapping (r3 <= r3 + r3).
    drive(1, 0, 1, 3, 3, 3, 1, 44, 0, 0, 0);
    cycle();
    check("alias_a",   32'(bus.outPhysA),   3);
    check("alias_old", 32'(bus.outOldPhys), 3);

    // Commit/rewind recovery restores the committed mapping.
    drive(1, 0, 1, 0, 0, 4, 1, 40, 0, 0, 0);  cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 40);  cycle();
    drive(1, 0, 1, 0, 0, 4, 1, 41, 0, 0, 0);  cycle();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   cycle();
    drive(1, 0, 1, 4, 9, 2, 0, 0, 0, 0, 0);   cycle();
    check("r032_a",   32'(bus.outPhysA), 40);
    check("r032_b",   32'(bus.outPhysB), 9);

    // Rewind + rename + commit on one edge.
    drive(1, 1, 1, 1, 2, 6, 1, 55, 1, 6, 50);
    cycle();
    check("r033_valid", 32'(bus.outValid), 0);
    drive(1, 0, 1, 6, 6, 0, 0, 0, 0, 0, 0);   cycle();
    check("r033_map6", 32'(bus.outPhysA), 50);

    // en=0 freezes everything.
    drive(0, 0, 1, 6, 6, 6, 1, 60, 1, 6, 61);
    cycle();
    check("r034_hold_valid", 32'(bus.outValid), 1);
    check("r034_hold_a",     32'(bus.outPhysA), 50);
    drive(1, 0, 1, 6, 6, 0, 0, 0, 0, 0, 0);   cycle();
    check("r034_map6", 32'(bus.outPhysA), 50);

    // Reset mid-stream, with activity asserted, restores identity maps.
    reset = 1'b1;
    drive(1, 1, 1, 6, 6, 6, 1, 62, 1, 6, 63);
    cycle();
    check("r034_rst_valid", 32'(bus.outValid), 0);
    reset = 1'b0;
    drive(1, 0, 1, 6, 4, 9, 0, 0, 0, 0, 0);   cycle();
    check("r034_id_a",   32'(bus.outPhysA),   6);
    check("r034_id_old", 32'(bus.outOldPhys), 9);

`ifdef RMT_ZERO_REG_EN
    drive(1, 0, 1, 0, 0, 0, 1, 45, 1, 0, 46); cycle();
    check("r035_a",    32'(bus.outPhysA),    0);
    check("r035_dest", 32'(bus.outPhysDest), 0);
`else
    drive(1, 0, 1, 0, 0, 0, 1, 45, 0, 0, 0);  cycle();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);   cycle();
    check("r029_reg0", 32'(bus.outPhysA), 45);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) != 0,
            $urandom_range(0, 24) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 4) != 0, $urandom_range(0, 63),
            $urandom_range(0, 2) == 0, $urandom_range(0, 31), $urandom_range(0, 63));
      cycle();
    end
    reset = 1'b0;
    idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rename_map_table.md
RENAME_MAP_TABLE -- requirements
Module: rename_map_table

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port en, input, 1 bit: when 0, all state and registered outputs hold; reset still acts.
REQ-004 SHALL have port rewind, input, 1 bit: copy committed map into speculative map.
REQ-005 SHALL have port rename, input, 1 bit: one instruction presented for renaming this cycle.
REQ-006 SHALL have ports srcA and srcB, input, 5 bits each: architectural source registers.
REQ-007 SHALL have port dest, input, 5 bits: architectural destination register.
REQ-008 SHALL have port destValid, input, 1 bit: the instruction writes dest.
REQ-009 SHALL have port newPhys, input, 6 bits: free physical register offered by the free list.
REQ-010 SHALL have port takeReq, output, 1 bit: combinational; drives the free list take and enableTake inputs.
REQ-011 SHALL have ports commit (input, 1 bit), commitDest (input, 5 bits) and commitPhys (input, 6 bits): retiring mapping.
REQ-012 SHALL have ports outValid (output, 1 bit), outPhysA (output, 6 bits) and outPhysB (output, 6 bits): registered renamed sources.
REQ-013 SHALL have ports outPhysDest (output, 6 bits) and outOldPhys (output, 6 bits): registered new destination mapping and displaced mapping, the latter later freed via the free list put port.

Function
REQ-014 SHALL hold two 32x6-bit maps: specMap (speculative) and commMap (committed).
REQ-015 SHALL assert takeReq = en & rename & destValid & ~rewind.
REQ-016 SHALL, on a rename edge with en=1 and rewind=0, register outPhysA=specMap[srcA], outPhysB=specMap[srcB] and outOldPhys=specMap[dest], all read before this instruction's update, and set outValid=1.
REQ-017 SHALL register outPhysDest=newPhys when destValid=1, else outPhysDest=specMap[dest] with specMap unchanged.
REQ-018 SHALL write specMap[dest]<=newPhys on the same edge when takeReq=1, so the next instruction sees it; latency is 1 cycle with no internal bypass needed.
REQ-019 SHALL set outValid=0 on any enabled edge without an accepted rename; other outputs then hold.
REQ-020 SHALL write commMap[commitDest]<=commitPhys on an enabled edge with commit=1.
REQ-021 SHALL, on rewind=1, load specMap from commMap including the same-edge commit update, drop any concurrent rename, and set outValid=0.
REQ-022 SHALL, when srcA, srcB or dest equal each other, apply read-before-write to all reads (e.g. r3<=r3+r3 reads the old r3 mapping).
REQ-023 SHALL have no full/empty handling; free-list availability is the upstream stall's job (en).

Reset
REQ-024 SHALL, on reset, set specMap[i]=commMap[i]=i for i=0..31, consistent with free list holding 32..63.
REQ-025 SHALL, on reset, drive outValid=0 and outPhysA=outPhysB=outPhysDest=outOldPhys=0.
REQ-026 SHALL let reset take priority over en, rewind, rename and commit, including mid-operation.

Configuration
REQ-027 SHALL support macro RMT_ZERO_REG_EN.
REQ-028 SHALL, when RMT_ZERO_REG_EN is defined, treat arch reg 0 as hardwired: sources 0 read phys 0, dest 0 acts as destValid=0 (takeReq=0, no map write), and commits to dest 0 are ignored.
REQ-029 SHALL, when RMT_ZERO_REG_EN is undefined, rename reg 0 like any other register.

Verification
REQ-030 SHALL cover: after reset, rename srcA=5, srcB=7, dest=9, newPhys=32 -> next cycle outPhysA=5, outPhysB=7, outOldPhys=9, outPhysDest=32, outValid=1, takeReq was 1.
REQ-031 SHALL cover: back-to-back renames dest=9/newPhys=32, then srcA=9, dest=9, newPhys=33 -> second output outPhysA=32, outOldPhys=32, outPhysDest=33.
REQ-032 SHALL cover: rename dest=4 (newPhys=40), commit 4->40, rename dest=4 (newPhys=41), rewind -> a subsequent rename of srcA=4 yields 40.
REQ-033 SHALL cover: rewind+rename+commit(6->50) on the same edge -> outValid=0, specMap[6]=50, takeReq=0 that cycle.
REQ-034 SHALL cover: en=0 while rename=1 -> takeReq=0, outputs and maps unchanged; reset asserted mid-stream -> identity maps, outValid=0.
REQ-035 SHALL cover, with RMT_ZERO_REG_EN: rename dest=0, srcA=0 -> takeReq=0, outPhysA=0, outPhysDest=0.
